// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one byte-level SPI engine between NUM_REQ requesters.
// It latches command/length, forwards read bytes, enforces a CS gap and aborts hung transfers.
module spi_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 65535,
    parameter int MIN_GAP = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [8*NUM_REQ-1:0]    req_cmd,
    input  logic [16*NUM_REQ-1:0]   req_len,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [7:0]              rd_data,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_err,
    output logic                    eng_start,
    output logic [7:0]              eng_command,
    output logic [15:0]             eng_read_byte_count,
    output logic                    eng_abort,
    input  logic                    eng_done,
    input  logic                    eng_rd_valid,
    input  logic [7:0]              eng_rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_BUSY     = 3'd2;
    localparam logic [2:0] S_ABORT    = 3'd3;
    localparam logic [2:0] S_COMPLETE = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    logic [2:0]       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] pick;
    logic             pick_hit;
    logic [WD_W-1:0]  wd_cnt;
    logic [15:0]      byte_cnt;
    logic [15:0]      byte_cnt_next;
    logic [GAP_W-1:0] gap_cnt;
    logic             err;

    // Round-robin search: first set request after last_grant, wrapping around.
    always_comb begin
        pick     = last_grant;
        pick_hit = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!pick_hit && req[cand]) begin
                pick     = cand;
                pick_hit = 1'b1;
            end
        end
    end

    // A byte arriving together with eng_done still counts toward the length check.
    assign byte_cnt_next = (eng_rd_valid && byte_cnt != 16'hFFFF) ? byte_cnt + 16'd1 : byte_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            last_grant          <= IDX_W'(NUM_REQ - 1);
            cur_idx             <= '0;
            gnt                 <= '0;
            rd_valid            <= '0;
            rd_data             <= '0;
            eng_command         <= '0;
            eng_read_byte_count <= '0;
            wd_cnt              <= '0;
            byte_cnt            <= '0;
            gap_cnt             <= '0;
            err                 <= 1'b0;
        end else begin
            rd_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_hit) begin
                        gnt                 <= NUM_REQ'(1) << pick;
                        cur_idx             <= pick;
                        eng_command         <= req_cmd[{pick, 3'b000} +: 8];
                        eng_read_byte_count <= req_len[{pick, 4'b0000} +: 16];
                        byte_cnt            <= '0;
                        wd_cnt              <= '0;
                        err                 <= 1'b0;
                        state               <= S_START;
                    end
                end
                S_START: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    wd_cnt   <= wd_cnt + WD_W'(1);
                    byte_cnt <= byte_cnt_next;
                    if (eng_rd_valid) begin
                        rd_valid <= gnt;
                        rd_data  <= eng_rd_data;
                    end
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (eng_done) begin
                        err   <= (byte_cnt_next != eng_read_byte_count);
                        state <= S_COMPLETE;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    err   <= 1'b1;
                    state <= S_COMPLETE;
                end
                S_COMPLETE: begin
                    last_grant <= cur_idx;
                    gnt        <= '0;
                    gap_cnt    <= '0;
                    state      <= (MIN_GAP == 0) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(MIN_GAP - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign eng_start = (state == S_START);
    assign eng_abort = (state == S_ABORT);
    assign req_done  = (state == S_COMPLETE) ? gnt : '0;
    assign req_err   = (state == S_COMPLETE) && err;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: contention, single transfer, length mismatch,
// zero-length, timeout, simultaneous done/timeout and mid-transfer reset.
module tb_spi_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 100;
    localparam int MIN_GAP = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [8*NUM_REQ-1:0]  req_cmd;
    logic [16*NUM_REQ-1:0] req_len;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [7:0]            rd_data;
    logic [NUM_REQ-1:0]    req_done;
    logic                  req_err;
    logic                  eng_start;
    logic [7:0]            eng_command;
    logic [15:0]           eng_read_byte_count;
    logic                  eng_abort;
    logic                  eng_done;
    logic                  eng_rd_valid;
    logic [7:0]            eng_rd_data;

    int checks = 0;
    int failures = 0;
    int stray_cnt = 0;
    int multi_gnt_cnt = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int n;

    spi_bus_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(TIMEOUT),
        .MIN_GAP(MIN_GAP)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req                 (req),
        .req_cmd             (req_cmd),
        .req_len             (req_len),
        .gnt                 (gnt),
        .rd_valid            (rd_valid),
        .rd_data             (rd_data),
        .req_done            (req_done),
        .req_err             (req_err),
        .eng_start           (eng_start),
        .eng_command         (eng_command),
        .eng_read_byte_count (eng_read_byte_count),
        .eng_abort           (eng_abort),
        .eng_done            (eng_done),
        .eng_rd_valid        (eng_rd_valid),
        .eng_rd_data         (eng_rd_data)
    );

    always #5 clk = ~clk;

    // Background monitors for invariants that must hold on every cycle.
    always @(negedge clk) begin
        if ((rd_valid & ~gnt) != '0) stray_cnt <= stray_cnt + 1;
        if ($countones(gnt) > 1) multi_gnt_cnt <= multi_gnt_cnt + 1;
        if (eng_start) start_cnt <= start_cnt + 1;
        if (eng_abort) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive engine inputs for one clock edge, then sample point is #1 after that edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic done);
        eng_rd_valid = v;
        eng_rd_data  = d;
        eng_done     = done;
        @(posedge clk);
        #1;
        eng_rd_valid = 1'b0;
        eng_rd_data  = 8'h00;
        eng_done     = 1'b0;
    endtask

    task automatic idleCycles(input int k);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic waitGrant(output int cnt);
        cnt = 0;
        do begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            cnt++;
        end while (gnt == '0 && cnt < 50);
    endtask

    initial begin
        reset_n      = 1'b0;
        req          = '0;
        req_cmd      = {8'hB1, 8'hA0};
        req_len      = {16'd1, 16'd1};
        eng_done     = 1'b0;
        eng_rd_valid = 1'b0;
        eng_rd_data  = 8'h00;

        idleCycles(3);
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_eng_start", 32'(eng_start), 32'h0);
        checkOutput("rst_eng_command", 32'(eng_command), 32'h0);
        checkOutput("rst_req_done", 32'(req_done), 32'h0);
        reset_n = 1'b1;
        idleCycles(2);

        // Contention: both requesters held, grants alternate starting with 0.
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_gnt;
            logic [7:0] exp_cmd;
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_cmd = (i % 2 == 0) ? 8'hA0 : 8'hB1;
            waitGrant(n);
            checkOutput($sformatf("cont%0d_latency", i), 32'(n), (i == 0) ? 32'd1 : 32'd6);
            checkOutput($sformatf("cont%0d_gnt", i), 32'(gnt), 32'(exp_gnt));
            checkOutput($sformatf("cont%0d_start", i), 32'(eng_start), 32'h1);
            checkOutput($sformatf("cont%0d_cmd", i), 32'(eng_command), 32'(exp_cmd));
            applyStimulus(1'b0, 8'h00, 1'b0);
            applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0);
            checkOutput($sformatf("cont%0d_rd_valid", i), 32'(rd_valid), 32'(exp_gnt));
            checkOutput($sformatf("cont%0d_rd_data", i), 32'(rd_data), 32'h30 + 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("cont%0d_done", i), 32'(req_done), 32'(exp_gnt));
            checkOutput($sformatf("cont%0d_err", i), 32'(req_err), 32'h0);
        end
        req = '0;
        idleCycles(10);

        // Single requester: cmd 0x9F, three bytes; later edits to req/cmd/len must not leak in.
        req_cmd[7:0]  = 8'h9F;
        req_len[15:0] = 16'd3;
        req = 2'b01;
        waitGrant(n);
        checkOutput("t1_latency", 32'(n), 32'd1);
        checkOutput("t1_gnt", 32'(gnt), 32'h1);
        checkOutput("t1_start", 32'(eng_start), 32'h1);
        checkOutput("t1_cmd", 32'(eng_command), 32'h9F);
        checkOutput("t1_len", 32'(eng_read_byte_count), 32'd3);
        req = '0;
        req_cmd[7:0]  = 8'h00;
        req_len[15:0] = 16'd7;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1_start_once", 32'(eng_start), 32'h0);
        checkOutput("t1_cmd_held", 32'(eng_command), 32'h9F);
        checkOutput("t1_len_held", 32'(eng_read_byte_count), 32'd3);
        applyStimulus(1'b1, 8'hEF, 1'b0);
        checkOutput("t1_b0_valid", 32'(rd_valid), 32'h1);
        checkOutput("t1_b0_data", 32'(rd_data), 32'hEF);
        applyStimulus(1'b1, 8'h40, 1'b0);
        checkOutput("t1_b1_data", 32'(rd_data), 32'h40);
        applyStimulus(1'b1, 8'h18, 1'b0);
        checkOutput("t1_b2_valid", 32'(rd_valid), 32'h1);
        checkOutput("t1_b2_data", 32'(rd_data), 32'h18);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1_done", 32'(req_done), 32'h1);
        checkOutput("t1_err", 32'(req_err), 32'h0);
        checkOutput("t1_gnt_in_complete", 32'(gnt), 32'h1);

        // Byte-count mismatch: len 4, only 2 bytes; also measures the CS gap.
        req_cmd[7:0]  = 8'h03;
        req_len[15:0] = 16'd4;
        req = 2'b01;
        waitGrant(n);
        checkOutput("gap_cycles", 32'(n), 32'd6);
        checkOutput("mm_gnt", 32'(gnt), 32'h1);
        checkOutput("mm_len", 32'(eng_read_byte_count), 32'd4);
        req = '0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("mm_done", 32'(req_done), 32'h1);
        checkOutput("mm_err", 32'(req_err), 32'h1);
        idleCycles(10);

        // Zero-length command-only transfer on requester 1.
        req_cmd[15:8]  = 8'h05;
        req_len[31:16] = 16'd0;
        req = 2'b10;
        waitGrant(n);
        checkOutput("len0_gnt", 32'(gnt), 32'h2);
        checkOutput("len0_len", 32'(eng_read_byte_count), 32'd0);
        req = '0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("len0_done", 32'(req_done), 32'h2);
        checkOutput("len0_err", 32'(req_err), 32'h0);
        idleCycles(10);

        // Timeout: engine stays silent; abort after 100 BUSY cycles.
        req_cmd[7:0]  = 8'h0B;
        req_len[15:0] = 16'd1;
        req = 2'b01;
        waitGrant(n);
        req = '0;
        n = 0;
        do begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            n++;
        end while (!eng_abort && n < 200);
        checkOutput("to_abort_cycle", 32'(n), 32'd101);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("to_done", 32'(req_done), 32'h1);
        checkOutput("to_err", 32'(req_err), 32'h1);
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("to_late_byte", 32'(rd_valid), 32'h0);
        checkOutput("to_late_done", 32'(req_done), 32'h0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        checkOutput("to_late_byte2", 32'(rd_valid), 32'h0);
        idleCycles(10);

        // eng_done with a final byte in the very cycle the watchdog expires.
        req_cmd[7:0]  = 8'h0C;
        req_len[15:0] = 16'd2;
        req = 2'b01;
        waitGrant(n);
        req = '0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("sim_b0_data", 32'(rd_data), 32'h11);
        idleCycles(98);
        applyStimulus(1'b1, 8'h22, 1'b1);
        checkOutput("sim_no_abort", 32'(eng_abort), 32'h0);
        checkOutput("sim_done", 32'(req_done), 32'h1);
        checkOutput("sim_err", 32'(req_err), 32'h0);
        checkOutput("sim_b1_valid", 32'(rd_valid), 32'h1);
        checkOutput("sim_b1_data", 32'(rd_data), 32'h22);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("sim_no_abort_after", 32'(eng_abort), 32'h0);
        idleCycles(10);

        // Reset in the middle of BUSY, then both requesters asking.
        req_len[15:0] = 16'd4;
        req = 2'b01;
        waitGrant(n);
        req = '0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b0);
        checkOutput("start_count", 32'(start_cnt), 32'd10);
        reset_n = 1'b0;
        req = 2'b11;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mrst_gnt", 32'(gnt), 32'h0);
        checkOutput("mrst_req_done", 32'(req_done), 32'h0);
        checkOutput("mrst_any_output", 32'(|{rd_valid, rd_data, req_err, eng_start,
                                             eng_command, eng_read_byte_count, eng_abort}), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mrst_req_done2", 32'(req_done), 32'h0);
        reset_n = 1'b1;
        waitGrant(n);
        checkOutput("mrst_latency", 32'(n), 32'd1);
        checkOutput("mrst_first_gnt", 32'(gnt), 32'h1);

        checkOutput("no_stray_rd_valid", 32'(stray_cnt), 32'd0);
        checkOutput("gnt_onehot", 32'(multi_gnt_cnt), 32'd0);
        checkOutput("abort_count", 32'(abort_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one byte-level SPI controller engine between NUM_REQ requesters, e.g. sensor config, flash read and debug.
- The engine sends one command byte, then reads len bytes.
- The arbiter picks requesters round-robin, latches the command and length, starts the engine, and routes read bytes back to the winning requester.
- It enforces a chip-select gap between transactions, runs a watchdog, and checks the byte count.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- TIMEOUT, 65535: max clk cycles from eng_start to eng_done before abort.
- MIN_GAP, 4: idle clk cycles after each transaction before the next grant.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester level request; sampled only in IDLE
- req_cmd  in  8*NUM_REQ  command byte, slice i = [8i+7:8i]
- req_len  in  16*NUM_REQ  read byte count, slice i = [16i+15:16i]
- gnt  out  NUM_REQ  one-hot; high from acceptance through the COMPLETE cycle
- rd_valid  out  NUM_REQ  one-cycle pulse to the granted requester per read byte
- rd_data  out  8  read byte, shared; qualified by rd_valid
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_err  out  1  valid with req_done; 1 = timeout or byte-count mismatch
- eng_start  out  1  one-cycle start pulse to the engine
- eng_command  out  8  latched command, stable through BUSY
- eng_read_byte_count  out  16  latched length, stable through BUSY
- eng_abort  out  1  one-cycle abort pulse; the engine must release CS
- eng_done  in  1  engine completion pulse
- eng_rd_valid  in  1  engine read-byte strobe
- eng_rd_data  in  8  engine read byte

Behaviour:
- Reset values:
  - All outputs are 0; state is IDLE; counters are 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first after reset.
  - Reset mid-transaction drops gnt immediately; req_done is not issued.
- State IDLE:
  - If any req bit is set, choose the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch that requester's cmd and len into eng_command / eng_read_byte_count.
  - Set gnt[i], clear byte_cnt and wd_cnt, then go to START.
  - Latency from req rising to gnt high is 1 clk.
- State START: eng_start = 1 for exactly one cycle, then go to BUSY.
- State BUSY:
  - wd_cnt increments every cycle.
  - On eng_rd_valid: rd_valid[i] = 1 with rd_data = eng_rd_data in the next cycle (1-cycle registered latency); byte_cnt increments.
  - byte_cnt saturates at 16'hFFFF.
  - On eng_done: err = (byte_cnt, including any same-cycle eng_rd_valid, != latched len); go to COMPLETE.
  - If wd_cnt reaches TIMEOUT-1 without eng_done: go to ABORT.
  - eng_done in the same cycle as the timeout: eng_done wins, no abort.
- State ABORT: eng_abort = 1 for one cycle; err = 1; go to COMPLETE.
- State COMPLETE:
  - req_done[i] = 1 and req_err = err for one cycle; gnt[i] is still high this cycle.
  - last_grant = i; go to GAP.
- State GAP: count MIN_GAP cycles with gnt = 0, then go to IDLE. MIN_GAP = 0 goes straight to IDLE.
- Request and input rules:
  - Dropping req or changing req_cmd / req_len after grant has no effect.
  - A requester holding req after req_done is eligible again, but only in round-robin order.
- Ignored engine inputs:
  - eng_rd_valid and eng_done outside BUSY are ignored, including late bytes after an abort.
  - No rd_valid is ever forwarded to a non-granted requester.
- len = 0 is legal: command-only transaction; eng_done with zero bytes gives err = 0.
- Invariants: gnt is always one-hot or zero; at most one eng_start per grant.

Test Plan:
- Single requester: req[0] with cmd 0x9F, len 3; engine returns 0xEF, 0x40, 0x18 then eng_done. Expect: gnt[0] 1 clk after req; one eng_start with eng_command 0x9F and count 3; three rd_valid[0] with those bytes in order; req_done[0] with req_err = 0; next gnt no sooner than MIN_GAP+1 clk later.
- Contention: req = 2'b11 held continuously, 4 transactions. Expect grant order 0,1,0,1, and no rd_valid ever on the non-granted bit.
- Timeout: TIMEOUT = 100; engine never pulses eng_done. Expect eng_abort at the 100th BUSY cycle; req_done[0] with req_err = 1; a later stray eng_rd_valid is not forwarded.
- Byte-count mismatch: len = 4, engine returns 2 bytes then eng_done. Expect req_err = 1; len = 0 with an immediate eng_done gives req_err = 0.
- Reset mid-BUSY: assert reset_n = 0 after 2 bytes. Expect all outputs 0 next clk and no req_done; after release with req = 2'b11, requester 0 is granted first.
- Simultaneous events: eng_done in the same cycle as the timeout gives no eng_abort. A final eng_rd_valid in the same cycle as eng_done is counted, giving req_err = 0 when the count matches.
